// File: rtl/gs_elim_sched_if.sv
// Host load/unload streams between the host and the elimination job scheduler.
// Master is the host side; slave is the scheduler side.
interface gs_elim_sched_if #(
    parameter int unsigned DAT_W = 64
);
    logic             host_wr_valid;
    logic [DAT_W-1:0] host_wr_data;
    logic             host_wr_ready;
    logic             host_rd_valid;
    logic [DAT_W-1:0] host_rd_data;
    logic             host_rd_ready;

    modport master (
        output host_wr_valid, host_wr_data, host_rd_ready,
        input  host_wr_ready, host_rd_valid, host_rd_data
    );

    modport slave (
        input  host_wr_valid, host_wr_data, host_rd_ready,
        output host_wr_ready, host_rd_valid, host_rd_data
    );
endinterface

// File: rtl/gs_elim_sched.sv
// Job scheduler for a row-based elimination engine: loads DAT_D rows from the host,
// lends the row memory to the engine until it finishes, then streams the rows back.
module gs_elim_sched #(
    parameter int unsigned DAT_W = 64,
    parameter int unsigned DAT_D = 64,
    parameter int unsigned AW    = (DAT_D > 1) ? $clog2(DAT_D) : 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             host_start,
    gs_elim_sched_if.slave   host,
    output logic             eng_start,
    input  logic             eng_finish,
    input  logic [AW-1:0]    eng_addr,
    input  logic             eng_rw,
    input  logic [DAT_W-1:0] eng_dout,
    output logic [DAT_W-1:0] eng_din,
    output logic [AW-1:0]    mem_addr,
    output logic [DAT_W-1:0] mem_wdata,
    output logic             mem_rden,
    output logic             mem_wren,
    input  logic [DAT_W-1:0] mem_q,
    output logic             busy,
    output logic             done
);

    localparam logic [AW-1:0] LAST_ROW = AW'(DAT_D - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_URD,
        S_UHOLD,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [DAT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wr_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             eng_start_q;

    assign host.host_wr_ready = wr_ready_q;
    assign host.host_rd_valid = rd_valid_q;
    assign host.host_rd_data  = rd_data_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign eng_start          = eng_start_q;
    assign eng_din            = mem_q;

    // State register; status outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            eng_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            wr_ready_q  <= (state_d == S_LOAD);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            eng_start_q <= (state_d == S_START);
        end
    end

    // Next-state and memory-port steering.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_rden   = 1'b0;
        mem_wren   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (host_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                mem_addr = cnt_q;
                if (host.host_wr_valid && wr_ready_q) begin
                    mem_wren  = 1'b1;
                    mem_wdata = host.host_wr_data;
                    if (cnt_q == LAST_ROW) begin
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                mem_addr  = eng_addr;
                mem_wdata = eng_dout;
                mem_wren  = eng_rw;
                mem_rden  = ~eng_rw;
                if (eng_finish) begin
                    state_d = S_URD;
                    cnt_d   = '0;
                end
            end
            S_URD: begin
                mem_addr = cnt_q;
                mem_rden = 1'b1;
                state_d  = S_UHOLD;
            end
            S_UHOLD: begin
                // First cycle captures the read data; valid is then held until accepted.
                if (!rd_valid_q) begin
                    rd_data_d  = mem_q;
                    rd_valid_d = 1'b1;
                end else if (host.host_rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (cnt_q == LAST_ROW) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + AW'(1);
                        state_d = S_URD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gs_elim_sched.sv
// Directed bench for gs_elim_sched (8-bit rows, 4 rows) with a row-level reference model
// and a single negedge compare process.
module tb_gs_elim_sched;

    localparam int unsigned DW = 8;
    localparam int unsigned DD = 4;
    localparam int unsigned AWT = 2;

    logic           clk = 1'b0;
    logic           rst_b = 1'b1;
    logic           host_start = 1'b0;
    logic           eng_finish = 1'b0;
    logic           eng_rw = 1'b0;
    logic [AWT-1:0] eng_addr = '0;
    logic [DW-1:0]  eng_dout = '0;
    logic           eng_start;
    logic [DW-1:0]  eng_din;
    logic [AWT-1:0] mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic           mem_rden;
    logic           mem_wren;
    logic [DW-1:0]  mem_q = '0;
    logic           busy;
    logic           done;
    logic [DW-1:0]  ram [DD];

    gs_elim_sched_if #(.DAT_W(DW)) host_if ();

    gs_elim_sched #(.DAT_W(DW), .DAT_D(DD), .AW(AWT)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .host_start (host_start),
        .host       (host_if),
        .eng_start  (eng_start),
        .eng_finish (eng_finish),
        .eng_addr   (eng_addr),
        .eng_rw     (eng_rw),
        .eng_dout   (eng_dout),
        .eng_din    (eng_din),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rden   (mem_rden),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Row memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        if (mem_rden) mem_q <= ram[mem_addr];
    end

    // Reference model state, written only by the stimulus process.
    logic [DW-1:0] load_vals [DD];
    logic [DW-1:0] model_mem [DD];
    logic          in_run = 1'b0;
    string         lit_name [$];
    logic [31:0]   lit_act  [$];
    logic [31:0]   lit_exp  [$];

    // Compare-process state.
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            lit_i = 0;
    int            wr_n = 0;
    int            es_n = 0;
    int            rd_n = 0;
    int            done_n = 0;
    int            wr_cyc [DD];
    logic [DW-1:0] rd_got [DD];
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic          busy_chk = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        lit_name.push_back(nm);
        lit_act.push_back(act);
        lit_exp.push_back(exp);
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            cyc++;
            while (lit_i < lit_name.size()) begin
                chk(lit_name[lit_i], lit_act[lit_i], lit_exp[lit_i]);
                lit_i++;
            end
            if (!rst_b) begin
                wr_n = 0; es_n = 0; rd_n = 0;
                hold_pend = 1'b0; busy_chk = 1'b0;
            end else begin
                chk("rden_wren_exclusive", 32'(mem_rden & mem_wren), 0);
                chk("eng_din_is_mem_q", 32'(eng_din), 32'(mem_q));
                if (busy_chk) begin
                    chk("busy_after_done", 32'(busy), 0);
                    busy_chk = 1'b0;
                end
                if (!busy) begin
                    chk("idle_quiet", 32'({mem_rden, mem_wren, eng_start, host_if.host_wr_ready,
                                           host_if.host_rd_valid, done}), 0);
                    if (host_start) begin
                        wr_n = 0; es_n = 0; rd_n = 0;
                    end
                end
                if (in_run) begin
                    chk("run_passthru", 32'({mem_addr, mem_wdata, mem_wren, mem_rden}),
                        32'({eng_addr, eng_dout, eng_rw, ~eng_rw}));
                    chk("run_host_blocked", 32'({host_if.host_wr_ready, host_if.host_rd_valid}), 0);
                end else if (mem_wren) begin
                    if (wr_n < int'(DD)) begin
                        chk("load_addr", 32'(mem_addr), 32'(wr_n));
                        chk("load_data", 32'(mem_wdata), 32'(load_vals[wr_n]));
                        wr_cyc[wr_n] = cyc;
                    end else begin
                        chk("extra_write", 1, 0);
                    end
                    wr_n++;
                end
                if (eng_start) begin
                    chk("eng_start_rows_loaded", 32'(wr_n), DD);
                    chk("eng_start_latency", 32'(cyc), 32'(wr_cyc[DD-1] + 1));
                    es_n++;
                end
                if (hold_pend)
                    chk("rd_hold_stable", 32'({host_if.host_rd_valid, host_if.host_rd_data}),
                        32'({1'b1, hold_data}));
                if (host_if.host_rd_valid && host_if.host_rd_ready) begin
                    if (rd_n < int'(DD)) begin
                        chk("unload_row", 32'(host_if.host_rd_data), 32'(model_mem[rd_n]));
                        rd_got[rd_n] = host_if.host_rd_data;
                    end else begin
                        chk("extra_read", 1, 0);
                    end
                    rd_n++;
                end
                hold_pend = host_if.host_rd_valid && !host_if.host_rd_ready;
                hold_data = host_if.host_rd_data;
                if (done) begin
                    chk("done_all_rows", 32'(rd_n), DD);
                    chk("done_one_eng_start", 32'(es_n), 1);
                    busy_chk = 1'b1;
                    done_n++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
    endtask

    task automatic load_row(input logic [DW-1:0] d, input int gap);
        int n = 0;
        host_if.host_wr_valid = 1'b1;
        host_if.host_wr_data  = d;
        while (!host_if.host_wr_ready && n < 50) begin tick(); n++; end
        if (!host_if.host_wr_ready) lit("timeout_wr_ready", 0, 1);
        tick();
        host_if.host_wr_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_eng_start();
        int n = 0;
        while (!eng_start && n < 50) begin tick(); n++; end
        if (!eng_start) lit("timeout_eng_start", 0, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin tick(); n++; end
        if (!done) lit("timeout_done", 0, 1);
    endtask

    task automatic unload(input int stall_row);
        for (int r = 0; r < int'(DD); r++) begin
            int n = 0;
            host_if.host_rd_ready = (r != stall_row);
            while (!host_if.host_rd_valid && n < 50) begin tick(); n++; end
            if (!host_if.host_rd_valid) lit("timeout_rd_valid", 0, 1);
            if (r == stall_row) begin
                repeat (2) tick();
                lit("stall_rd_data", 32'(host_if.host_rd_data), 32'(model_mem[r]));
                host_if.host_rd_ready = 1'b1;
            end
            tick();
        end
        host_if.host_rd_ready = 1'b0;
    endtask

    task automatic set_job(input logic [DW-1:0] a, b, c, d);
        load_vals[0] = a; load_vals[1] = b; load_vals[2] = c; load_vals[3] = d;
        for (int i = 0; i < int'(DD); i++) model_mem[i] = load_vals[i];
    endtask

    task automatic check_rows(input logic [DW-1:0] a, b, c, d);
        lit("row0", 32'(rd_got[0]), 32'(a));
        lit("row1", 32'(rd_got[1]), 32'(b));
        lit("row2", 32'(rd_got[2]), 32'(c));
        lit("row3", 32'(rd_got[3]), 32'(d));
    endtask

    initial begin : stim
        int n;
        host_if.host_wr_valid = 1'b0;
        host_if.host_wr_data  = '0;
        host_if.host_rd_ready = 1'b0;
        #1 rst_b = 1'b0;
        #2;
        lit("reset_outputs", 32'({busy, done, eng_start, host_if.host_wr_ready,
                                  host_if.host_rd_valid, mem_rden, mem_wren}), 0);
        lit("reset_rd_data", 32'(host_if.host_rd_data), 0);
        tick(); tick();
        rst_b = 1'b1;
        tick();

        // Job 1: back-to-back load, engine write/read, stalled unload.
        set_job(8'h11, 8'h22, 8'h33, 8'h44);
        pulse_start();
        for (int i = 0; i < int'(DD); i++) load_row(load_vals[i], 0);
        wait_eng_start();
        lit("job1_write_span", 32'(wr_cyc[3] - wr_cyc[0]), 3);
        tick();
        lit("eng_start_one_cycle", 32'(eng_start), 0);
        in_run = 1'b1;
        eng_rw = 1'b1; eng_addr = 2'd2; eng_dout = 8'hA5;
        host_if.host_wr_valid = 1'b1; host_if.host_wr_data = 8'hEE;
        #1;
        lit("run_eng_write", 32'({mem_wren, mem_addr, mem_wdata, host_if.host_wr_ready}),
            32'({1'b1, 2'd2, 8'hA5, 1'b0}));
        tick();
        model_mem[2] = 8'hA5;
        eng_rw = 1'b0; eng_addr = 2'd1; host_if.host_wr_valid = 1'b0;
        tick();
        lit("eng_read_row1", 32'(eng_din), 32'h22);
        eng_finish = 1'b1;
        tick();
        eng_finish = 1'b0; in_run = 1'b0;
        unload(1);
        wait_done();
        check_rows(8'h11, 8'h22, 8'hA5, 8'h44);
        tick();
        lit("busy_low_after_job1", 32'(busy), 0);

        // Job 2: gapped load with engine noise outside RUN, host_start ignored while busy.
        set_job(8'h5A, 8'h6B, 8'h7C, 8'h8D);
        pulse_start();
        eng_rw = 1'b1; eng_addr = 2'd3; eng_dout = 8'hFF; eng_finish = 1'b1;
        for (int i = 0; i < int'(DD); i++) begin
            load_row(load_vals[i], (i < int'(DD) - 1) ? 1 : 0);
            eng_finish = 1'b0;
        end
        wait_eng_start();
        lit("job2_write_span", 32'(wr_cyc[3] - wr_cyc[0]), 6);
        eng_rw = 1'b0;
        tick();
        in_run = 1'b1; host_start = 1'b1;
        tick();
        host_start = 1'b0; eng_finish = 1'b1;
        tick();
        eng_finish = 1'b0; in_run = 1'b0;
        unload(-1);
        wait_done();
        check_rows(8'h5A, 8'h6B, 8'h7C, 8'h8D);
        tick();

        // Job 3: reset mid-load, then a fresh job restarts at row 0.
        set_job(8'h01, 8'h02, 8'h03, 8'h04);
        pulse_start();
        load_row(8'h01, 0);
        load_row(8'h02, 0);
        lit("rd_data_held_before_reset", 32'(host_if.host_rd_data), 32'h8D);
        #2 rst_b = 1'b0;
        #1;
        lit("async_reset_outputs", 32'({busy, done, eng_start, host_if.host_wr_ready,
                                        host_if.host_rd_valid, mem_rden, mem_wren}), 0);
        lit("async_reset_rd_data", 32'(host_if.host_rd_data), 0);
        lit("async_reset_addr_wdata", 32'({mem_addr, mem_wdata}), 0);
        tick();
        rst_b = 1'b1;
        tick();
        lit("post_reset_idle", 32'({busy, host_if.host_wr_ready}), 0);
        set_job(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        pulse_start();
        for (int i = 0; i < int'(DD); i++) load_row(load_vals[i], 0);
        wait_eng_start();
        lit("job3_write_span", 32'(wr_cyc[3] - wr_cyc[0]), 3);
        tick();
        in_run = 1'b1; eng_finish = 1'b1;
        tick();
        eng_finish = 1'b0; in_run = 1'b0;
        unload(2);
        wait_done();
        check_rows(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        tick(); tick();
        lit("done_pulses", 32'(done_n), 3);

        n = 0;
        while (lit_i < lit_name.size() && n < 10) begin tick(); n++; end
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
